// File: rtl/bus_interconnect_if.sv
// Native-bus bundle between one picorv32-style master, the interconnect and its slaves.
// The slave modport is the interconnect's view; the master modport is the environment's view.
interface bus_interconnect_if #(
    parameter int NUM_SLAVES = 4
) ();
    logic                       m_valid;
    logic                       m_ready;
    logic [31:0]                m_addr;
    logic [31:0]                m_wdata;
    logic [3:0]                 m_wstrb;
    logic [31:0]                m_rdata;

    logic [NUM_SLAVES-1:0]      s_valid;
    logic [NUM_SLAVES-1:0]      s_ready;
    logic [31:0]                s_addr;
    logic [31:0]                s_wdata;
    logic [3:0]                 s_wstrb;
    logic [32*NUM_SLAVES-1:0]   s_rdata;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/bus_interconnect.sv
// Single-master address-decoding interconnect with slave wait timeout and error reporting.
// state  | meaning
// IDLE   | waiting for m_valid; request latched and decoded on acceptance
// ACCESS | s_valid asserted to the selected slave, wait counter running
// RESP   | m_ready pulse to the master, then back to IDLE
module bus_interconnect #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_LSB    = 28,
    parameter int          SEL_W      = 4,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    bus_interconnect_if.slave    bus,
    output logic                 err_irq,
    output logic [31:0]          err_addr,
    output logic [15:0]          err_count
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t                 state;
    logic [15:0]            wait_cnt;
    logic [31:0]            sel_idx;
    logic                   sel_hit;
    logic [NUM_SLAVES-1:0]  sel_onehot;
    logic                   ready_sel;
    logic [31:0]            rdata_sel;
    logic [15:0]            err_count_next;

    always_comb begin
        sel_idx    = 32'(bus.m_addr[SEL_LSB +: SEL_W]);
        sel_hit    = sel_idx < 32'(NUM_SLAVES);
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot[i] = (sel_idx == 32'(i));
        end
    end

    // s_valid is one-hot on the selected slave during ACCESS, so it doubles as the
    // ready/rdata select and other slaves' s_ready can never complete a transfer.
    always_comb begin
        ready_sel = |(bus.s_ready & bus.s_valid);
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (bus.s_valid[i]) begin
                rdata_sel = bus.s_rdata[32*i +: 32];
            end
        end
        err_count_next = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bus.m_ready <= 1'b0;
            bus.m_rdata <= '0;
            bus.s_valid <= '0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_wstrb <= '0;
            err_irq     <= 1'b0;
            err_addr    <= '0;
            err_count   <= '0;
        end else begin
            bus.m_ready <= 1'b0;
            err_irq     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_valid) begin
                        bus.s_addr  <= bus.m_addr;
                        bus.s_wdata <= bus.m_wdata;
                        bus.s_wstrb <= bus.m_wstrb;
                        if (sel_hit) begin
                            bus.s_valid <= sel_onehot;
                            wait_cnt    <= '0;
                            state       <= ACCESS;
                        end else begin
                            bus.m_rdata <= ERR_DATA;
                            bus.m_ready <= 1'b1;
                            err_irq     <= 1'b1;
                            err_addr    <= bus.m_addr;
                            err_count   <= err_count_next;
                            state       <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // A ready arriving on the final wait cycle wins over the timeout.
                    if (ready_sel) begin
                        bus.m_rdata <= rdata_sel;
                        bus.s_valid <= '0;
                        bus.m_ready <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt    <= wait_cnt + 16'd1;
                        bus.m_rdata <= ERR_DATA;
                        bus.s_valid <= '0;
                        bus.m_ready <= 1'b1;
                        err_irq     <= 1'b1;
                        err_addr    <= bus.s_addr;
                        err_count   <= err_count_next;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 4, giving the number of slave ports (1..16).
REQ-002 The block SHALL have parameter SEL_LSB, default 28, giving the lowest address bit of the slave-select field.
REQ-003 The block SHALL have parameter SEL_W, default 4, giving the slave-select field width; index = m_addr[SEL_LSB +: SEL_W].
REQ-004 The block SHALL have parameter TIMEOUT, default 255, giving the maximum slave wait cycles (1..65535).
REQ-005 The block SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, giving the read data returned on any error.
REQ-006 The block SHALL have one clock and a synchronous active-low reset: clk  in  1  single clock; all logic on rising edge.
REQ-007 resetn  in  1  synchronous, active-low reset.
REQ-008 m_valid  in  1  master request (picorv32 native bus).
REQ-009 m_ready  out  1  one-cycle transfer-complete strobe.
REQ-010 m_addr  in  32  byte address.
REQ-011 m_wdata  in  32  write data.
REQ-012 m_wstrb  in  4  byte enables; 0 = read.
REQ-013 m_rdata  out  32  registered read data.
REQ-014 s_valid  out  NUM_SLAVES  per-slave request, one-hot or zero.
REQ-015 s_ready  in  NUM_SLAVES  per-slave completion.
REQ-016 s_addr, s_wdata, s_wstrb  out  32/32/4  shared, registered copies of the latched request.
REQ-017 s_rdata  in  32*NUM_SLAVES  flattened; slave i occupies bits [32*i +: 32].
REQ-018 err_irq  out  1  one-cycle error pulse.
REQ-019 err_addr  out  32  address of the most recent error.
REQ-020 err_count  out  16  saturating error counter.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ACCESS and RESP.
REQ-022 In IDLE with m_valid=1, the block SHALL latch addr/wdata/wstrb into s_addr/s_wdata/s_wstrb and decode the index.
REQ-023 From IDLE, if index < NUM_SLAVES the block SHALL go to ACCESS; otherwise it SHALL flag a decode error and go to RESP.
REQ-024 In ACCESS, s_valid[index] SHALL be 1 and all other s_valid bits SHALL be 0.
REQ-025 In ACCESS, s_ready[index]=1 SHALL capture s_rdata slice index into m_rdata, deassert s_valid next cycle and go to RESP.
REQ-026 The block SHALL ignore s_ready bits of non-selected slaves in every state.
REQ-027 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without s_ready[index].
REQ-028 When the wait counter reaches TIMEOUT, the block SHALL raise a timeout error, drop s_valid, set m_rdata=ERR_DATA and go to RESP.
REQ-029 If s_ready[index] arrives in the same cycle the counter reaches TIMEOUT, the block SHALL treat it as a success with no error.
REQ-030 In RESP, m_ready SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE; m_rdata SHALL hold until the next capture.
REQ-031 On a decode error, m_rdata SHALL be ERR_DATA, no s_valid SHALL assert, and any write SHALL be discarded.
REQ-032 Latency SHALL be: m_valid accepted in cycle 0, s_valid in cycle 1, and s_ready in cycle k (k>=1) giving m_ready in cycle k+1.
REQ-033 A decode error SHALL produce m_ready in cycle 1.
REQ-034 Master inputs SHALL be ignored outside IDLE, and m_valid sampled in RESP SHALL NOT start a new transfer.
REQ-035 On any error, err_irq SHALL pulse in the cycle RESP is entered, err_addr SHALL load the latched address, and err_count SHALL increment, saturating at 16'hFFFF.
REQ-036 A write error SHALL still complete with m_ready, so the CPU never stalls.

Reset
REQ-037 With resetn=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-038 With resetn=0, m_ready, s_valid and err_irq SHALL be 0.
REQ-039 With resetn=0, m_rdata, s_addr, s_wdata, s_wstrb, err_addr, err_count and the wait counter SHALL be 0.
REQ-040 A reset mid-ACCESS SHALL abort the transfer: s_valid drops the next cycle, no m_ready is given, and no error is recorded.

Verification
REQ-041 The bench SHALL read 0x1000_0004 with slave 1 s_ready=1 immediately and s_rdata1=0x12345678 -> s_valid=0010 in cycle 1, m_ready in cycle 2, m_rdata=0x12345678.
REQ-042 The bench SHALL write 0x2000_0000 with wstrb=0011 and slave 2 ready after 5 cycles -> s_wstrb=0011, m_ready 1 cycle after s_ready, err_count=0.
REQ-043 The bench SHALL read 0x7000_0000 with NUM_SLAVES=4 -> m_ready in cycle 1, m_rdata=0xDEADBEEF, err_irq pulse, err_addr=0x7000_0000, err_count=1.
REQ-044 The bench SHALL run with slave 0 never ready and TIMEOUT=8 -> s_valid high 8 cycles, m_rdata=0xDEADBEEF, err_irq pulse, s_valid=0 after.
REQ-045 The bench SHALL assert s_ready on slave 3 while slave 0 is selected -> ignored; slave 0 ready later completes normally.
REQ-046 The bench SHALL pulse resetn=0 for 1 cycle during ACCESS -> s_valid=0 next cycle, no m_ready, err_count unchanged at 0, and a new request is served normally.
